// File: rtl/shift_left_logical_seq_pkg.sv
// Shared types and sizes for the sequential RV32I logical left shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package shift_pkg;

  // Datapath width; only 32 is supported.
  localparam int XLEN = 32;

  // Shift-amount width, log2(XLEN).
  localparam int SHAMT_W = 5;

  // Stage counter is wide enough to hold 0..SHAMT_W-1.
  localparam int CNT_W = 3;

  // Index of the last shift stage; the FSM leaves SHIFT after applying it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHAMT_W - 1);

  // Unit control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

endpackage : shift_pkg

// File: rtl/shift_left_logical_seq_if.sv
// Request/result bundle between ALU dispatch and the sequential left shifter.
// Latency: n/a (wires only).
// Backpressure: dispatcher holds valid_i and operands until ready_o is seen high.
interface shift_left_logical_seq_if;
  import shift_pkg::*;

  logic            valid_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            ready_o;
  logic            valid_o;
  logic [XLEN-1:0] rd_o;

  // Dispatcher side: issues requests, consumes the result strobe.
  modport master (
    output valid_i,
    output rs1_i,
    output rs2_i,
    input  ready_o,
    input  valid_o,
    input  rd_o
  );

  // Shifter side: accepts requests, produces the result strobe.
  modport slave (
    input  valid_i,
    input  rs1_i,
    input  rs2_i,
    output ready_o,
    output valid_o,
    output rd_o
  );

endinterface : shift_left_logical_seq_if

// File: rtl/shift_left_logical_seq_mux.sv
// 32-bit 2:1 mux used as the single per-stage shift selector.
// Latency: combinational.
// Backpressure: none.
module mux2to1_32bit
  import shift_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            sel_i,
  output logic [XLEN-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule : mux2to1_32bit

// File: rtl/shift_left_logical_seq.sv
// Multi-cycle SLL/SLLI unit: resolves one shamt bit per cycle through one 2:1 mux stage.
// Latency: 6 cycles accept-to-valid_o, fixed for every shamt; one op per 7 cycles.
// Backpressure: ready_o low while busy; valid_i then is ignored, not queued.
module shift_left_logical_seq
  import shift_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  shift_left_logical_seq_if.slave     bus
);

  shift_state_e       state_q;
  shift_state_e       state_d;
  logic [XLEN-1:0]    data_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [XLEN-1:0]    w_stage_shifted;
  logic [XLEN-1:0]    w_stage_out;
  logic               w_stage_sel;
  logic               w_ready;
  logic               w_valid;
  logic               w_accept;
  logic               w_last_stage;

  // Upper rs2 bits carry no meaning for RV32I shifts.
  logic               w_unused_rs2_hi;
  assign w_unused_rs2_hi = ^bus.rs2_i[XLEN-1:SHAMT_W];

  // Shift amount for this stage is 1<<cnt_q, realised as fixed-distance shifts.
  always_comb begin
    w_stage_shifted = data_q;
    case (cnt_q)
      3'd0:    w_stage_shifted = data_q << 1;
      3'd1:    w_stage_shifted = data_q << 2;
      3'd2:    w_stage_shifted = data_q << 4;
      3'd3:    w_stage_shifted = data_q << 8;
      3'd4:    w_stage_shifted = data_q << 16;
      default: w_stage_shifted = data_q;
    endcase
  end

  assign w_stage_sel  = shamt_q[cnt_q];
  assign w_last_stage = (cnt_q == CNT_LAST);

  mux2to1_32bit u_stage_mux (
    .a_i   (data_q),
    .b_i   (w_stage_shifted),
    .sel_i (w_stage_sel),
    .y_o   (w_stage_out)
  );

  // Next-state and handshake outputs; outputs depend on state only.
  always_comb begin
    state_d  = state_q;
    w_ready  = 1'b0;
    w_valid  = 1'b0;
    w_accept = 1'b0;
    case (state_q)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.valid_i) begin
          w_accept = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last_stage) begin
          state_d = DONE;
        end
      end
      DONE: begin
        w_valid = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any request in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      shamt_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        data_q  <= bus.rs1_i;
        shamt_q <= bus.rs2_i[SHAMT_W-1:0];
        cnt_q   <= '0;
      end else if (state_q == SHIFT) begin
        data_q <= w_stage_out;
        // Wrap to 0 after the last stage so cnt_q never indexes past shamt_q.
        cnt_q  <= w_last_stage ? '0 : cnt_q + 1'b1;
      end
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.valid_o = w_valid;
  assign bus.rd_o    = data_q;

endmodule : shift_left_logical_seq

// File: tb/tb_shift_left_logical_seq.sv
// Directed and random checks of the sequential left shifter's result and cycle timing.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_shift_left_logical_seq;

  logic clk_i;
  logic rst_i;
  int   n_tests;
  int   n_fail;

  shift_left_logical_seq_if bus ();

  shift_left_logical_seq dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request in the current (idle) cycle T and check cycles T+1..T+7.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    chk($sformatf("%s ready@T", tag), {31'b0, bus.ready_o}, 32'd1);
    bus.valid_i = 1'b1;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    for (int c = 1; c <= 7; c++) begin
      tick();
      bus.valid_i = 1'b0;
      bus.rs1_i   = $urandom;
      bus.rs2_i   = $urandom;
      chk($sformatf("%s valid@T+%0d", tag, c), {31'b0, bus.valid_o}, {31'b0, c == 6});
      chk($sformatf("%s ready@T+%0d", tag, c), {31'b0, bus.ready_o}, {31'b0, c == 7});
      if (c >= 6) chk($sformatf("%s rd@T+%0d", tag, c), bus.rd_o, exp);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    n_tests     = 0;
    n_fail      = 0;
    rst_i       = 1'b1;
    bus.valid_i = 1'b0;
    bus.rs1_i   = 32'h0;
    bus.rs2_i   = 32'h0;

    // Reset held for two cycles.
    tick();
    tick();
    rst_i = 1'b0;
    chk("reset ready", {31'b0, bus.ready_o}, 32'd1);
    chk("reset valid", {31'b0, bus.valid_o}, 32'd0);
    chk("reset rd", bus.rd_o, 32'h0000_0000);

    // Directed vectors.
    run_op(32'h0000_0001, 32'h0000_001F, 32'h8000_0000, "basic31");
    run_op(32'hDEAD_BEEF, 32'hFFFF_FF24, 32'hEADB_EEF0, "mask4");
    run_op(32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, "zero");
    run_op(32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, "mask32");
    run_op(32'h8000_0001, 32'h0000_0001, 32'h0000_0002, "shl1");
    run_op(32'h1234_5678, 32'h0000_0002, 32'h48D1_59E0, "shl2");
    run_op(32'h1234_5678, 32'h0000_0010, 32'h5678_0000, "shl16");
    run_op(32'hFFFF_FFFF, 32'h0000_001F, 32'h8000_0000, "allones31");
    run_op(32'hA5A5_A5A5, 32'h0000_000C, 32'h5A5A_5000, "shl12");

    // Request held high while busy with changing operands: only the first runs.
    bus.valid_i = 1'b1;
    bus.rs1_i   = 32'h1234_5678;
    bus.rs2_i   = 32'h0000_0008;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c <= 6) begin
        bus.rs1_i = 32'hFFFF_FFFF - 32'(c);
        bus.rs2_i = 32'(c);
      end else begin
        bus.rs1_i = 32'hAAAA_AAAA;
        bus.rs2_i = 32'h0000_0003;
      end
      if (c == 8) bus.valid_i = 1'b0;
      chk($sformatf("hold valid@T+%0d", c), {31'b0, bus.valid_o}, {31'b0, c == 6 || c == 13});
      chk($sformatf("hold ready@T+%0d", c), {31'b0, bus.ready_o}, {31'b0, c == 7});
      if (c == 6)  chk("hold rd first", bus.rd_o, 32'h3456_7800);
      if (c == 13) chk("hold rd second", bus.rd_o, 32'h5555_5550);
    end
    tick();
    chk("hold back idle", {31'b0, bus.ready_o}, 32'd1);

    // Reset pulsed mid-operation at T+3.
    bus.valid_i = 1'b1;
    bus.rs1_i   = 32'hFFFF_FFFF;
    bus.rs2_i   = 32'h0000_0010;
    tick();
    bus.valid_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("abort ready", {31'b0, bus.ready_o}, 32'd1);
    chk("abort valid", {31'b0, bus.valid_o}, 32'd0);
    chk("abort rd", bus.rd_o, 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("abort quiet %0d", c), {31'b0, bus.valid_o}, 32'd0);
    end
    run_op(32'hFFFF_FFFF, 32'h0000_0010, 32'hFFFF_0000, "after abort");

    // Reset and request in the same cycle: reset wins.
    rst_i       = 1'b1;
    bus.valid_i = 1'b1;
    bus.rs1_i   = 32'h0000_00FF;
    bus.rs2_i   = 32'h0000_0004;
    tick();
    rst_i       = 1'b0;
    bus.valid_i = 1'b0;
    chk("rst prio ready", {31'b0, bus.ready_o}, 32'd1);
    chk("rst prio rd", bus.rd_o, 32'h0);

    // Random sweep against the reference shift.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(ra, rb, ra << rb[4:0], $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_shift_left_logical_seq
